// File: rtl/chip8_pkg.sv
// Shared screen geometry, FSM state type and pixel indexing for the CHIP-8 frame streamer.
package chip8_pkg;

  localparam int unsigned SCR_W   = 64;
  localparam int unsigned SCR_H   = 32;
  localparam int unsigned FB_BITS = 2048;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

  function automatic logic [10:0] idx(input logic [5:0] x, input logic [4:0] y);
    return 11'(y) * 11'(SCR_W) + 11'(x);
  endfunction

endpackage

// File: rtl/chip8_scan_counter.sv
// Nested sx/x/sy/y scan counters for row-major traversal with SCALE x SCALE pixel replication.
module chip8_scan_counter
  import chip8_pkg::*;
#(
  parameter int unsigned SCALE = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [5:0] x_o,
  output logic [4:0] y_o,
  output logic       sof_o,
  output logic       eol_o,
  output logic       eof_o,
  output logic       wrap_o
);

  localparam int unsigned SW = $clog2(SCALE) + 1;
  localparam logic [SW-1:0] SLast = SW'(SCALE - 1);

  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [5:0]    x_q, x_d;
  logic [4:0]    y_q, y_d;
  logic          sx_last, x_last, sy_last, y_last;

  assign sx_last = (sx_q == SLast);
  assign x_last  = (x_q == 6'(SCR_W - 1));
  assign sy_last = (sy_q == SLast);
  assign y_last  = (y_q == 5'(SCR_H - 1));

  always_comb begin
    sx_d = sx_q;
    x_d  = x_q;
    sy_d = sy_q;
    y_d  = y_q;
    if (clear_i) begin
      sx_d = '0;
      x_d  = '0;
      sy_d = '0;
      y_d  = '0;
    end else if (advance_i) begin
      // Each level only moves when every inner level wraps; y wraps 31->0 by width.
      if (sx_last) begin
        sx_d = '0;
        if (x_last) begin
          x_d = '0;
          if (sy_last) begin
            sy_d = '0;
            y_d  = y_q + 5'd1;
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end else begin
          x_d = x_q + 6'd1;
        end
      end else begin
        sx_d = sx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sx_q <= '0;
      x_q  <= '0;
      sy_q <= '0;
      y_q  <= '0;
    end else begin
      sx_q <= sx_d;
      x_q  <= x_d;
      sy_q <= sy_d;
      y_q  <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign sof_o  = (sx_q == '0) && (x_q == '0) && (sy_q == '0) && (y_q == '0);
  assign eol_o  = sx_last && x_last;
  assign eof_o  = eol_o && sy_last && y_last;
  assign wrap_o = advance_i && eof_o;

endmodule

// File: rtl/chip8_frame_streamer.sv
// Snapshots the 64x32 framebuffer on start and streams it as scaled, colour-mapped pixel beats.
module chip8_frame_streamer
  import chip8_pkg::*;
#(
  parameter int unsigned         SCALE    = 1,
  parameter int unsigned         PIX_W    = 12,
  parameter logic [PIX_W-1:0]    FG_COLOR = PIX_W'(12'hFFF),
  parameter logic [PIX_W-1:0]    BG_COLOR = PIX_W'(12'h000)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FB_BITS-1:0] display,
  input  logic               start,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic               frame_done
);

  state_e             state_q, state_d;
  logic [FB_BITS-1:0] snap_q, snap_d;
  logic               frame_done_q, frame_done_d;
  logic               accept, xfer, streaming;
  logic [5:0]         x;
  logic [4:0]         y;
  logic               sof, eol, eof, wrap;

  assign streaming = (state_q == StStream);
  assign xfer      = streaming && pix_ready;

  chip8_scan_counter #(
    .SCALE (SCALE)
  ) u_scan (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (accept),
    .advance_i (xfer),
    .x_o       (x),
    .y_o       (y),
    .sof_o     (sof),
    .eol_o     (eol),
    .eof_o     (eof),
    .wrap_o    (wrap)
  );

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    accept       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          snap_d  = display;
          state_d = StStream;
        end
      end
      StStream: begin
        // start is deliberately not looked at here: requests while streaming are dropped.
        if (wrap) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign busy       = streaming;
  assign pix_valid  = streaming;
  assign pix_data   = (streaming && snap_q[idx(x, y)]) ? FG_COLOR : BG_COLOR;
  assign pix_sof    = streaming && sof;
  assign pix_eol    = streaming && eol;
  assign pix_eof    = streaming && eof;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_chip8_frame_streamer.sv
// Randomized bench for chip8_frame_streamer, checked against an arithmetic beat model.
module tb_chip8_frame_streamer;

  logic          clk;
  logic          rst_n;
  logic [2047:0] disp_a, disp_b;
  logic          start_a, start_b, ready_a, ready_b;
  logic          busy_a, valid_a, sof_a, eol_a, eof_a, done_a;
  logic          busy_b, valid_b, sof_b, eol_b, eof_b, done_b;
  logic [11:0]   data_a, data_b;

  int n_checks = 0;
  int n_errors = 0;

  chip8_frame_streamer #(.SCALE(1)) dut_a (
    .clk        (clk),
    .reset      (rst_n),
    .display    (disp_a),
    .start      (start_a),
    .busy       (busy_a),
    .pix_valid  (valid_a),
    .pix_ready  (ready_a),
    .pix_data   (data_a),
    .pix_sof    (sof_a),
    .pix_eol    (eol_a),
    .pix_eof    (eof_a),
    .frame_done (done_a)
  );

  chip8_frame_streamer #(.SCALE(2)) dut_b (
    .clk        (clk),
    .reset      (rst_n),
    .display    (disp_b),
    .start      (start_b),
    .busy       (busy_b),
    .pix_valid  (valid_b),
    .pix_ready  (ready_b),
    .pix_data   (data_b),
    .pix_sof    (sof_b),
    .pix_eol    (eol_b),
    .pix_eof    (eof_b),
    .frame_done (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {data, sof, eol, eof} of output beat n for a frame of snapshot s at scale sc.
  function automatic logic [14:0] exp_beat(input logic [2047:0] s, input int n, input int sc);
    int w, line, col, px, py;
    logic [11:0] d;
    w    = 64 * sc;
    line = n / w;
    col  = n % w;
    px   = col / sc;
    py   = line / sc;
    d    = s[py * 64 + px] ? 12'hFFF : 12'h000;
    return {d, n == 0, col == w - 1, n == 2048 * sc * sc - 1};
  endfunction

  function automatic logic [2047:0] rand_fb();
    logic [2047:0] r;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic start_frame_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  // Runs from the first beat of a frame on dut_a; entered and left at posedge+1.
  task automatic stream_a(input logic [2047:0] snap, input bit rnd, input int chg_cyc,
                          input logic [2047:0] chg_val, input int start_cyc,
                          input bit keep_start, input int abort_n);
    int n, cyc;
    bit stalled;
    logic [14:0] prev, cur;
    n = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (n < 2048 && cyc < 20000) begin
      ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == chg_cyc) disp_a = chg_val;
      if (!keep_start) start_a = (cyc == start_cyc);
      if (abort_n >= 0 && n == abort_n) begin
        rst_n = 1'b0;
        break;
      end
      @(negedge clk);
      cur = {data_a, sof_a, eol_a, eof_a};
      check_eq("busy_in_frame", 32'(busy_a), 32'd1);
      check_eq("valid_in_frame", 32'(valid_a), 32'd1);
      if (stalled) check_eq("stall_hold", 32'(cur), 32'(prev));
      if (valid_a && ready_a) begin
        check_eq("beat", 32'(cur), 32'(exp_beat(snap, n, 1)));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      prev = cur;
      @(posedge clk); #1;
      cyc++;
    end
    start_a = keep_start;
    if (abort_n < 0) begin
      check_eq("beat_count", 32'(n), 32'd2048);
      check_eq("frame_done", 32'(done_a), 32'd1);
      check_eq("valid_after_eof", 32'(valid_a), 32'd0);
      check_eq("busy_after_eof", 32'(busy_a), 32'd0);
    end
  endtask

  initial begin
    logic [2047:0] fb, fb2;
    int n, cyc, fg, fgsum;

    rst_n = 1'b0; start_a = 0; start_b = 0; ready_a = 1; ready_b = 1;
    disp_a = '0; disp_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a", {busy_a, valid_a, done_a, data_a, sof_a, eol_a, eof_a}, 32'd0);
    check_eq("rst_b", {busy_b, valid_b, done_b, data_b, sof_b, eol_b, eof_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Corner pixels, no stalls.
    fb = '0; fb[0] = 1'b1; fb[2047] = 1'b1;
    disp_a = fb;
    start_frame_a();
    stream_a(fb, 1'b0, -1, '0, -1, 1'b0, -1);

    // Random backpressure plus a start pulse that must be ignored mid-frame.
    @(posedge clk); #1;
    fb = rand_fb(); disp_a = fb;
    start_frame_a();
    stream_a(fb, 1'b1, -1, '0, 300, 1'b0, -1);

    // Display flips to all-ones mid-frame; snapshot must hold zeros.
    @(posedge clk); #1;
    disp_a = '0;
    start_frame_a();
    stream_a('0, 1'b0, 10, '1, -1, 1'b0, -1);
    start_frame_a();
    stream_a('1, 1'b1, -1, '0, -1, 1'b0, -1);

    // Reset at beat 1000 abandons the frame without frame_done.
    @(posedge clk); #1;
    fb = rand_fb(); disp_a = fb;
    start_frame_a();
    stream_a(fb, 1'b1, -1, '0, -1, 1'b0, 1000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_valid", 32'(valid_a), 32'd0);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("abort_no_done", 32'(done_a), 32'd0);
      @(posedge clk); #1;
    end
    fb = rand_fb(); disp_a = fb;
    start_frame_a();
    stream_a(fb, 1'b0, -1, '0, -1, 1'b0, -1);

    // Held start: next frame is accepted on the frame_done cycle and latches the new display.
    @(posedge clk); #1;
    fb = rand_fb(); disp_a = fb;
    start_a = 1'b1;
    @(posedge clk); #1;
    stream_a(fb, 1'b0, -1, '0, -1, 1'b1, -1);
    fb2 = rand_fb(); disp_a = fb2;
    @(posedge clk); #1;
    check_eq("b2b_valid", 32'(valid_a), 32'd1);
    check_eq("b2b_sof", 32'(sof_a), 32'd1);
    check_eq("b2b_done_clear", 32'(done_a), 32'd0);
    start_a = 1'b0;
    stream_a(fb2, 1'b1, -1, '0, -1, 1'b0, -1);

    // SCALE=2 instance, single lit pixel at (1,1).
    disp_b = '0; disp_b[65] = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0; cyc = 0; fg = 0; fgsum = 0;
    while (n < 8192 && cyc < 9000) begin
      @(negedge clk);
      if (valid_b) begin
        check_eq("beat_s2", 32'({data_b, sof_b, eol_b, eof_b}), 32'(exp_beat(disp_b, n, 2)));
        if (data_b == 12'hFFF) begin
          fg++;
          fgsum += n;
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("beat_count_s2", 32'(n), 32'd8192);
    check_eq("fg_count_s2", 32'(fg), 32'd4);
    check_eq("fg_pos_s2", 32'(fgsum), 32'd1290);
    check_eq("frame_done_s2", 32'(done_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
